// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures {instr, pc, pc+4} into a small FIFO
// and presents the head to decode over valid/ready; redirects flush and reload the PC.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4,
   output logic        halted
);

   localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0]    state;
   logic [31:0]   pc;
   logic [AW:0]   count;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [31:0]   instr_q [DEPTH];
   logic [31:0]   pc_q    [DEPTH];
   logic [31:0]   pc4_q   [DEPTH];

   logic push;
   logic pop;
   logic do_redirect;

   // A redirect blocks the head even in HALT so decode never sees a stale entry that cycle.
   assign do_redirect = redirect_valid && (state == ST_RUN);
   assign out_valid   = (count != '0) && !redirect_valid;
   assign pop         = out_valid && out_ready;
   assign push        = (state == ST_RUN) && !redirect_valid && ((count < FULL_COUNT) || pop);

   assign imem_addr    = pc;
   assign out_instr    = instr_q[rd_ptr];
   assign out_pc       = pc_q[rd_ptr];
   assign out_pc_plus4 = pc4_q[rd_ptr];
   assign halted       = (state == ST_HALT);

   // The link address is stored rather than added at the head so it reads zero out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_RUN;
         pc     <= RESET_PC;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
            pc4_q[i]   <= '0;
         end
      end else if (do_redirect) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         pc     <= {redirect_pc[31:2], 2'b00};
         if (redirect_pc[1:0] != 2'b00) begin
            state <= ST_HALT;
         end
      end else begin
         if (push) begin
            instr_q[wr_ptr] <= imem_data;
            pc_q[wr_ptr]    <= pc;
            pc4_q[wr_ptr]   <= pc + 32'd4;
            wr_ptr          <= wr_ptr + AW'(1);
            pc              <= pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (reset PC 0 and 0xFFFF_FFF8) share stimulus,
// each backed by its own combinational instruction memory model.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;

   logic [31:0] addrA, dataA, instrA, pcA, pc4A;
   logic        validA, haltedA;
   logic [31:0] addrB, dataB, instrB, pcB, pc4B;
   logic        validB, haltedB;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dutA (
      .clk(clk), .reset(reset), .imem_addr(addrA), .imem_data(dataA),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(validA), .out_ready(out_ready), .out_instr(instrA),
      .out_pc(pcA), .out_pc_plus4(pc4A), .halted(haltedA)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dutB (
      .clk(clk), .reset(reset), .imem_addr(addrB), .imem_data(dataB),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(validB), .out_ready(out_ready), .out_instr(instrB),
      .out_pc(pcB), .out_pc_plus4(pc4B), .halted(haltedB)
   );

   function automatic logic [31:0] imemModel(input logic [31:0] addr);
      if (addr == 32'h0)      return 32'h0052_0333;
      else if (addr == 32'h4) return 32'h4021_84b3;
      else                    return addr ^ 32'hDEAD_0000;
   endfunction

   assign dataA = imemModel(addrA);
   assign dataB = imemModel(addrB);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rpc,
                                input logic rdy);
      reset          = rst;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      // Reset state
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      tick(2);
      checkOutput("rst_valid",  {31'b0, validA},  32'h0);
      checkOutput("rst_halted", {31'b0, haltedA}, 32'h0);
      checkOutput("rst_instr",  instrA,           32'h0);
      checkOutput("rst_pc",     pcA,              32'h0);
      checkOutput("rst_pc4",    pc4A,             32'h0);
      checkOutput("rst_addr",   addrA,            32'h0);

      // First instruction one cycle after reset release, then back-to-back
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1);
      checkOutput("t1_valid", {31'b0, validA}, 32'h1);
      checkOutput("t1_instr", instrA,          32'h0052_0333);
      checkOutput("t1_pc",    pcA,             32'h0);
      checkOutput("t1_pc4",   pc4A,            32'h4);
      tick(1);
      checkOutput("t1_instr2", instrA, 32'h4021_84b3);
      checkOutput("t1_pc2",    pcA,    32'h4);
      checkOutput("t1_pc4_2",  pc4A,   32'h8);

      // Backpressure: FIFO fills, PC holds at 0x8
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      tick(5);
      checkOutput("t2_addr_hold", addrA,           32'h8);
      checkOutput("t2_head_pc",   pcA,             32'h0);
      checkOutput("t2_valid",     {31'b0, validA}, 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1);
      checkOutput("t2_head_4", pcA, 32'h4);
      tick(1);
      checkOutput("t2_head_8",  pcA,   32'h8);
      checkOutput("t2_addr_10", addrA, 32'h10);

      // Redirect to 0x20 while FIFO holds 0x8, 0xC
      applyStimulus(1'b0, 1'b1, 32'h20, 1'b1);
      checkOutput("t3_valid_redir", {31'b0, validA}, 32'h0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("t3_valid_gap", {31'b0, validA}, 32'h0);
      checkOutput("t3_addr",      addrA,           32'h20);
      tick(1);
      checkOutput("t3_valid_back", {31'b0, validA}, 32'h1);
      checkOutput("t3_head_20",    pcA,             32'h20);
      checkOutput("t3_instr_20",   instrA,          32'hDEAD_0020);
      tick(1);
      checkOutput("t3_head_24", pcA, 32'h24);

      // Misaligned redirect halts fetch
      applyStimulus(1'b0, 1'b1, 32'h22, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("t4_halted", {31'b0, haltedA}, 32'h1);
      checkOutput("t4_addr",   addrA,            32'h20);
      for (int i = 0; i < 10; i++) begin
         checkOutput("t4_valid_low", {31'b0, validA}, 32'h0);
         tick(1);
      end
      applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("t4_addr_ignored", addrA,            32'h20);
      checkOutput("t4_still_halted", {31'b0, haltedA}, 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("t4_rst_halted", {31'b0, haltedA}, 32'h0);
      checkOutput("t4_rst_addr",   addrA,            32'h0);
      tick(1);
      checkOutput("t4_restart_pc", pcA, 32'h0);

      // PC wrap on the high-reset-PC instance
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1);
      checkOutput("t5_pc_f8",    pcB,    32'hFFFF_FFF8);
      checkOutput("t5_pc4_f8",   pc4B,   32'hFFFF_FFFC);
      checkOutput("t5_instr_f8", instrB, 32'h2152_FFF8);
      tick(1);
      checkOutput("t5_pc_fc",  pcB,  32'hFFFF_FFFC);
      checkOutput("t5_pc4_fc", pc4B, 32'h0);
      tick(1);
      checkOutput("t5_pc_0",   pcB,              32'h0);
      checkOutput("t5_instr0", instrB,           32'h0052_0333);
      checkOutput("t5_valid",  {31'b0, validB},  32'h1);

      // Reset outranks a misaligned redirect in the same cycle
      applyStimulus(1'b1, 1'b1, 32'h22, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("t6_halted", {31'b0, haltedA}, 32'h0);
      checkOutput("t6_valid",  {31'b0, validA},  32'h0);
      checkOutput("t6_addr",   addrA,            32'h0);
      tick(1);
      checkOutput("t6_run_valid", {31'b0, validA}, 32'h1);
      checkOutput("t6_run_pc",    pcA,             32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
